spi_mnrch_gen: RTL

Parametrised SPI monarch (master) engine, the successor to the fixed 16-bit, mode-3, single-serf SPI monarch. It adds configurable word width, SCLK divide ratio, serf-select count and run-time SPI mode (CPOL/CPHA) selectable per transaction. It sits between the Segway control logic and SPI peripherals (inertial sensor, A2D) and is started by a single `wrt` pulse. It reports completion with a level `done`.

---
 rtl/spi_mnrch_gen.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_mnrch_gen.sv
// ---------------------------------------------------------------------------
// spi_mnrch_gen -- parametrised SPI monarch (master) engine
//
// Runs one full-duplex transfer of DATA_W bits per accepted `wrt` pulse.
// The word width, the SCLK divide ratio, the number of serf selects and the
// SPI mode are configurable. The mode is {CPOL,CPHA} and is latched for each
// transaction.
//
// Sequence: IDLE -> FRONT (H clks) -> DATA (DATA_W periods of 2H clks)
//           -> BACK (H clks) -> IDLE.
// The half-period is H = 2^(DIV_LOG2-1) clks.
//
// Parameters
//   DATA_W    bits per transaction (2..32)
//   DIV_LOG2  SCLK period = 2^DIV_LOG2 clk cycles (2..8)
//   NUM_SS    number of active-low serf selects (1..8)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   wrt        start request. Honoured only in IDLE and only with an in-range
//              ss_sel.
//   wt_data    word to transmit, latched at start
//   ss_sel     serf index, latched at start
//   mode       {CPOL,CPHA}, latched at start
//   lsb_first  (SPI_MNRCH_LSB_FIRST_EN builds only) LSB-first transfer,
//              latched at start
//   MISO       serial data from the serf
//   SCLK       serial clock (registered)
//   MOSI       serial data to the serf (registered)
//   SS_n       one-hot-low serf selects while a transfer is in flight
//   busy       high from acceptance until done rises
//   done       level, high after completion until the next accepted start
//   rd_data    received word, updated only at completion
//
// Optional feature macro: SPI_MNRCH_LSB_FIRST_EN
//   When defined, adds the lsb_first input. With lsb_first latched high, both
//   directions run LSB first.
//   When undefined, every transfer is MSB first.
// ---------------------------------------------------------------------------
module spi_mnrch_gen #(
  parameter int DATA_W   = 16,
  parameter int DIV_LOG2 = 4,
  parameter int NUM_SS   = 1,
  localparam int SW      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] wt_data,
  input  logic [SW-1:0]     ss_sel,
  input  logic [1:0]        mode,
`ifdef SPI_MNRCH_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  // Width of the bit counter. It counts 0..DATA_W-1.
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  // The phase counter spans one SCLK period. H-1 marks the end of a half
  // period. All-ones marks the end of a full period, so the counter wraps
  // back to zero by itself.
  localparam logic [DIV_LOG2-1:0] HALF_M1 = DIV_LOG2'((1 << (DIV_LOG2 - 1)) - 1);
  localparam logic [DIV_LOG2-1:0] FULL_M1 = {DIV_LOG2{1'b1}};

  // One extra bit so that NUM_SS itself fits in the range comparison.
  localparam logic [SW:0] SS_LIMIT = (SW + 1)'(NUM_SS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    DATA  = 2'd2,
    BACK  = 2'd3
  } state_t;

  state_t              state_q,   state_d;
  logic [DIV_LOG2-1:0] cnt_q,     cnt_d;
  logic [BW-1:0]       bit_q,     bit_d;
  logic [DATA_W-1:0]   tx_q,      tx_d;
  logic [DATA_W-1:0]   rx_q,      rx_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [1:0]          mode_q,    mode_d;
  logic                sclk_q,    sclk_d;
  logic                mosi_q,    mosi_d;
  logic [NUM_SS-1:0]   ss_n_q,    ss_n_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;

  // Shared signals for the start and completion logic.
  logic [NUM_SS-1:0]   ss_onehot_n;  // decoded select for the incoming ss_sel
  logic [DATA_W-1:0]   tx_load;      // word loaded into the MSB-first shifter
  logic [DATA_W-1:0]   rx_word;      // captured word as presented on rd_data
  logic                start_ok;
  logic                lead_edge;
  logic                trail_edge;

  // Decode ss_sel into an active-low one-hot select vector.
  generate
    for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
      assign ss_onehot_n[gi] = (ss_sel != SW'(gi));
    end
  endgenerate

`ifdef SPI_MNRCH_LSB_FIRST_EN
  // The shifter core always runs MSB first. An LSB-first transfer reverses
  // the word on the way in and the captured word on the way out.
  logic              lsb_q, lsb_d;
  logic [DATA_W-1:0] wt_rev;
  logic [DATA_W-1:0] rx_rev;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign wt_rev[gi] = wt_data[DATA_W-1-gi];
      assign rx_rev[gi] = rx_q[DATA_W-1-gi];
    end
  endgenerate

  assign tx_load = lsb_first ? wt_rev : wt_data;
  assign rx_word = lsb_q ? rx_rev : rx_q;

  always_comb begin
    lsb_d = lsb_q;
    if (start_ok) begin
      lsb_d = lsb_first;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsb_q <= 1'b0;
    end else begin
      lsb_q <= lsb_d;
    end
  end
`else
  assign tx_load = wt_data;
  assign rx_word = rx_q;
`endif

  // A start is accepted only from IDLE, and only when ss_sel names an
  // existing line. In IDLE busy is always low, so no separate busy check is
  // needed.
  assign start_ok   = (state_q == IDLE) && wrt && ({1'b0, ss_sel} < SS_LIMIT);
  assign lead_edge  = (state_q == DATA) && (cnt_q == HALF_M1);
  assign trail_edge = (state_q == DATA) && (cnt_q == FULL_M1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    mode_d    = mode_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      IDLE: begin
        // While idle, SCLK parks at the CPOL of the last latched mode.
        sclk_d = mode_q[1];
        if (start_ok) begin
          state_d = FRONT;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = tx_load;
          rx_d    = '0;
          mode_d  = mode;
          // A new CPOL is visible on SCLK on the first cycle after acceptance.
          sclk_d  = mode[1];
          mosi_d  = tx_load[DATA_W-1];
          ss_n_d  = ss_onehot_n;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end

      FRONT: begin
        cnt_d = cnt_q + DIV_LOG2'(1);
        if (cnt_q == HALF_M1) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end

      DATA: begin
        cnt_d = cnt_q + DIV_LOG2'(1);
        if (lead_edge) begin
          sclk_d = ~mode_q[1];
          if (!mode_q[0]) begin
            rx_d = {rx_q[DATA_W-2:0], MISO};
          end else if (bit_q != '0) begin
            // With CPHA=1 the first bit stays on MOSI through the first
            // leading edge. Later leading edges advance it.
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d = tx_q[DATA_W-2];
          end
        end
        if (trail_edge) begin
          sclk_d = mode_q[1];
          bit_d  = bit_q + BW'(1);
          if (mode_q[0]) begin
            rx_d = {rx_q[DATA_W-2:0], MISO};
          end else if (bit_q != LAST_BIT) begin
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d = tx_q[DATA_W-2];
          end
          if (bit_q == LAST_BIT) begin
            state_d = BACK;
            bit_d   = '0;
          end
        end
      end

      BACK: begin
        cnt_d = cnt_q + DIV_LOG2'(1);
        if (cnt_q == HALF_M1) begin
          state_d   = IDLE;
          cnt_d     = '0;
          ss_n_d    = '1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rd_data_d = rx_word;
          mosi_d    = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      mode_q    <= 2'b00;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      mode_q    <= mode_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS_n    = ss_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;

endmodule
